// File: rtl/string_match_pkg.sv
// Shared definitions for the streaming multi-pattern string matcher.
// Contents:
//   CHAR_W, DELIM  character width and the word delimiter (space)
//   MAX_LEN        pattern/window depth in characters
//   LEN_W, POS_W   widths of a length (0..MAX_LEN) and a character position
//   pat_entry_t    one pattern table entry {len, chars[MAX_LEN]}
//   rotl1()        width-generic rotate-left-by-one used by the rolling hash
package string_match_pkg;

    localparam int CHAR_W  = 8;
    localparam logic [CHAR_W-1:0] DELIM = 8'h20;
    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int POS_W   = $clog2(MAX_LEN);

    // chars[0] is the first character of the pattern in arrival order.
    typedef struct packed {
        logic [LEN_W-1:0]                  len;
        logic [MAX_LEN-1:0][CHAR_W-1:0]    chars;
    } pat_entry_t;

    // Rotate the low w bits of v left by one.  v must already be zero above
    // bit w-1; the result is masked to w bits.  w must be in 1..63.
    function automatic logic [63:0] rotl1(input logic [63:0] v, input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return ((v << 1) | (v >> (w - 1))) & mask;
    endfunction

endpackage

// File: rtl/string_pat_slice.sv
// One pattern lane of the multi-pattern matcher.
// Holds the pattern table entry, compares it against the next-state window,
// registers the hit as a one-cycle match pulse and keeps a saturating counter.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   cfg_we        write strobe already qualified for this lane
//   cfg_pos       character position to write (0 = first char)
//   cfg_char      character to store
//   cfg_len       pattern length (already clamped to MAX_LEN)
//   in_valid      a character is accepted this cycle
//   window_next   window after this cycle's shift, index 0 = newest char
//   fill_next     number of valid chars in window_next (0 after a delimiter)
//   match         registered hit pulse
//   hit_count     saturating hit counter
module string_pat_slice
    import string_match_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cfg_we,
    input  logic [POS_W-1:0]                cfg_pos,
    input  logic [CHAR_W-1:0]               cfg_char,
    input  logic [LEN_W-1:0]                cfg_len,
    input  logic                            in_valid,
    input  logic [MAX_LEN-1:0][CHAR_W-1:0]  window_next,
    input  logic [LEN_W-1:0]                fill_next,
    output logic                            match,
    output logic [CNT_W-1:0]                hit_count
);

    pat_entry_t         pat_q, pat_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               eq;

    always_comb begin
        // The compare uses pat_q, so a write in the same cycle only takes
        // effect from the next character on.
        eq = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            // Pattern char i pairs with the window slot (len-1-i) because
            // slot 0 holds the newest character.
            if (i < int'(pat_q.len)) begin
                if (window_next[POS_W'(int'(pat_q.len) - 1 - i)] != pat_q.chars[i]) begin
                    eq = 1'b0;
                end
            end
        end

        match_d = in_valid && (pat_q.len != '0) && (fill_next >= pat_q.len) && eq;

        cnt_d = cnt_q;
        if (match_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        pat_d = pat_q;
        if (cfg_we) begin
            pat_d.chars[cfg_pos] = cfg_char;
            pat_d.len            = cfg_len;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q   <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pat_q   <= pat_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
        end
    end

    assign match     = match_q;
    assign hit_count = cnt_q;

endmodule

// File: rtl/string_matcher_multi.sv
// Streaming multi-pattern string detector with a rolling word hash.
// Accepts one character per in_valid cycle and flags every occurrence
// (overlaps included) of NUM_PAT programmable patterns.  A delimiter
// character ends the current word: fill and hash restart from zero, so no
// pattern can match across it.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   in_valid      character qualifier
//   in_char       input character
//   cfg_we        pattern table write strobe
//   cfg_pat       pattern index to write
//   cfg_pos       character position (0 = first char)
//   cfg_char      character stored at cfg_pos
//   cfg_len       pattern length written with the character (>MAX_LEN clamps)
//   match         one-cycle pulse per pattern hit, latency 1
//   match_any     OR of match
//   hash_out      rolling hash of all characters of the current word
//   hit_count     saturating counters, pattern 0 in the LSBs
// Window depth (MAX_LEN), CHAR_W and DELIM come from string_match_pkg.
module string_matcher_multi
    import string_match_pkg::*;
#(
    parameter int NUM_PAT = 2,
    parameter int HASH_W  = 8,
    parameter int CNT_W   = 4,
    localparam int PAT_W  = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic [CHAR_W-1:0]           in_char,
    input  logic                        cfg_we,
    input  logic [PAT_W-1:0]            cfg_pat,
    input  logic [POS_W-1:0]            cfg_pos,
    input  logic [CHAR_W-1:0]           cfg_char,
    input  logic [LEN_W-1:0]            cfg_len,
    output logic [NUM_PAT-1:0]          match,
    output logic                        match_any,
    output logic [HASH_W-1:0]           hash_out,
    output logic [NUM_PAT*CNT_W-1:0]    hit_count
);

    // Slot 0 is the newest character; a shift moves older chars upward.
    logic [MAX_LEN-1:0][CHAR_W-1:0] window_q, window_d;
    logic [LEN_W-1:0]               fill_q, fill_d;
    logic [HASH_W-1:0]              hash_q, hash_d;
    logic [LEN_W-1:0]               cfg_len_c;

    always_comb begin
        window_d = window_q;
        fill_d   = fill_q;
        hash_d   = hash_q;
        if (in_valid) begin
            if (in_char == DELIM) begin
                fill_d = '0;
                hash_d = '0;
            end else begin
                window_d = {window_q[MAX_LEN-2:0], in_char};
                if (fill_q < LEN_W'(MAX_LEN)) begin
                    fill_d = fill_q + LEN_W'(1);
                end
                hash_d = HASH_W'(rotl1(64'(hash_q), HASH_W)) ^ HASH_W'(in_char);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window_q <= '0;
            fill_q   <= '0;
            hash_q   <= '0;
        end else begin
            window_q <= window_d;
            fill_q   <= fill_d;
            hash_q   <= hash_d;
        end
    end

    assign cfg_len_c = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;

    for (genvar g = 0; g < NUM_PAT; g++) begin : g_slice
        string_pat_slice #(
            .CNT_W (CNT_W)
        ) u_slice (
            .clk         (clk),
            .rst_n       (rst_n),
            .cfg_we      (cfg_we && (cfg_pat == PAT_W'(g))),
            .cfg_pos     (cfg_pos),
            .cfg_char    (cfg_char),
            .cfg_len     (cfg_len_c),
            .in_valid    (in_valid),
            .window_next (window_d),
            .fill_next   (fill_d),
            .match       (match[g]),
            .hit_count   (hit_count[g*CNT_W +: CNT_W])
        );
    end

    assign match_any = |match;
    assign hash_out  = hash_q;

endmodule
